acp_reg_sequencer: RTL

Bus initiator for the Audio Co-Processor (ACP/APU) MMIO register port ($4000–$401F). It accepts queued register commands (write or read, 5-bit offset, data, post-access wait count) and drives them onto the ACP register bus as single-cycle accesses. It paces the accesses with a programmable idle gap and returns read data with a valid strobe. It sits between test/boot logic or a sound-stream player and the ACP MMIO register block, in place of the CPU as bus master.

---
 rtl/acp_reg_sequencer.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/acp_reg_sequencer.sv
// ACP register-port bus initiator: queued write/read commands become single-cycle register accesses.
// Latency: command pushed at edge E0 into an idle block drives o_ce from E1 to E2; read data is strobed E2 to E3.
// Backpressure: o_cmd_ready follows the registered FIFO count and is low while full or in reset (no bypass path).
module acp_reg_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int WAIT_W     = 8
) (
    input  logic              i_clk_cpu,
    input  logic              i_reset,
    // command push side
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_rnw,
    input  logic [4:0]        i_cmd_addr,
    input  logic [7:0]        i_cmd_data,
    input  logic [WAIT_W-1:0] i_cmd_wait,
    // register bus
    output logic              o_ce,
    output logic              o_rnw,
    output logic [4:0]        o_addr,
    output logic [7:0]        o_data,
    input  logic [7:0]        i_rdata,
    // read return
    output logic              o_rd_valid,
    output logic [7:0]        o_rd_data,
    // status
    output logic              o_busy,
    output logic              o_err,
    input  logic              i_clear_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // FIFO entry layout: {rnw, addr[4:0], data[7:0], wait[WAIT_W-1:0]}
    localparam int ENT_W = 1 + 5 + 8 + WAIT_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [ENT_W-1:0]  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    logic [ENT_W-1:0]  w_head;
    logic              w_head_rnw;
    logic [4:0]        w_head_addr;
    logic [7:0]        w_head_data;
    logic [WAIT_W-1:0] w_head_wait;
    logic              w_head_legal;

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;

    logic              r_ce;
    logic              r_rnw;
    logic [4:0]        r_addr;
    logic [7:0]        r_data;
    logic              r_rd_valid;
    logic [7:0]        r_rd_data;
    logic              r_err;

    logic              w_issue;
    logic              w_illegal;
    logic              w_capture;

    // Offsets that accept writes; every offset is readable.
    function automatic logic f_wr_legal(input logic [4:0] a);
        logic ok;
        ok = 1'b0;
        case (a)
            5'h00, 5'h01, 5'h02, 5'h03,
            5'h04, 5'h05, 5'h06, 5'h07,
            5'h08, 5'h0A, 5'h0B, 5'h0C,
            5'h0E, 5'h0F, 5'h15, 5'h17: ok = 1'b1;
            default:                    ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    // Ready depends only on the registered count, so a pop never frees a slot for the same edge.
    assign o_cmd_ready = !w_full && !i_reset;
    assign w_push      = i_cmd_valid && o_cmd_ready;

    assign w_head       = r_mem[r_rd_ptr];
    assign w_head_rnw   = w_head[ENT_W-1];
    assign w_head_addr  = w_head[ENT_W-2 -: 5];
    assign w_head_data  = w_head[WAIT_W+7 -: 8];
    assign w_head_wait  = w_head[WAIT_W-1:0];
    assign w_head_legal = w_head_rnw || f_wr_legal(w_head_addr);

    // FIFO storage write; contents need no reset since the count gates every read.
    always_ff @(posedge i_clk_cpu) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_cmd_rnw, i_cmd_addr, i_cmd_data, i_cmd_wait};
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge i_clk_cpu or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge i_clk_cpu or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: an illegal write is dropped without leaving IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && w_head_legal) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (r_wait_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_wait_cnt == WAIT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM decode: when to pop, issue a bus cycle, flag an error or capture read data.
    always_comb begin
        w_pop     = 1'b0;
        w_issue   = 1'b0;
        w_illegal = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_pop     = !w_empty;
                w_issue   = !w_empty && w_head_legal;
                w_illegal = !w_empty && !w_head_legal;
            end
            S_ACCESS: begin
                w_capture = r_rnw;
            end
            default: begin
                w_pop = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------

    // Bus drivers: address/direction/data hold their last value between accesses.
    always_ff @(posedge i_clk_cpu or posedge i_reset) begin
        if (i_reset) begin
            r_ce   <= 1'b0;
            r_rnw  <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            r_ce <= w_issue;
            if (w_issue) begin
                r_rnw  <= w_head_rnw;
                r_addr <= w_head_addr;
                r_data <= w_head_data;
            end
        end
    end

    // Post-access idle counter: loaded on issue, counts down through WAIT.
    always_ff @(posedge i_clk_cpu or posedge i_reset) begin
        if (i_reset) begin
            r_wait_cnt <= '0;
        end else if (w_issue) begin
            r_wait_cnt <= w_head_wait;
        end else if (r_state == S_WAIT) begin
            r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
        end
    end

    // Read return: sample the combinational register data at the end of the ACCESS cycle.
    always_ff @(posedge i_clk_cpu or posedge i_reset) begin
        if (i_reset) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_capture;
            if (w_capture) begin
                r_rd_data <= i_rdata;
            end
        end
    end

    // Sticky error flag; a new illegal pop outranks a simultaneous clear.
    always_ff @(posedge i_clk_cpu or posedge i_reset) begin
        if (i_reset) begin
            r_err <= 1'b0;
        end else if (w_illegal) begin
            r_err <= 1'b1;
        end else if (i_clear_err) begin
            r_err <= 1'b0;
        end
    end

    assign o_ce       = r_ce;
    assign o_rnw      = r_rnw;
    assign o_addr     = r_addr;
    assign o_data     = r_data;
    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_data;
    assign o_err      = r_err;
    assign o_busy     = !w_empty || (r_state != S_IDLE);

endmodule
